mmio_slot_fabric: RTL and testbench
===================================

Name: mmio_slot_fabric

Overview:
Parametrised successor to the fixed 64-slot MMIO controller. Decodes host MMIO accesses into per-slot chip-select/read/write strobes, and holds each access until the addressed slot signals ready. Completed reads return through a registered response with a one-cycle ack. Adds a present-slot mask, wait-state handshake, timeout, error reporting and a busy/overrun indication. Sits between the FPro bus side of the MCS and the slot cores in the MMIO wrapper.

Parameters:
NUM_SLOTS, 64, number of slots; power of two, 2..64; SLOT_W = clog2(NUM_SLOTS)
REG_W, 5, register-address bits per slot
ADDR_W, 21, host address width; must be >= SLOT_W+REG_W
DATA_W, 32, data width
SLOT_PRESENT, 64'h0000_0000_0000_0031, bit i=1 means slot i is implemented
TIMEOUT, 16, maximum strobe cycles waiting for slot_ready (>=1)
ERR_DATA, 32'hFFFF_FFFF, read data returned on any error or unmapped access
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mmio_cs  in  1  host request strobe, one-cycle pulse
mmio_read  in  1  read qualifier
mmio_write  in  1  write qualifier
mmio_addr  in  ADDR_W  host address
mmio_wr_data  in  DATA_W  host write data
mmio_rd_data  out  DATA_W  registered read response
mmio_ack  out  1  one-cycle completion pulse
mmio_busy  out  1  access in progress
slot_cs  out  NUM_SLOTS  one-hot slot select
slot_mem_rd  out  NUM_SLOTS  one-hot read strobe
slot_mem_wr  out  NUM_SLOTS  one-hot write strobe
slot_mem_addr  out  REG_W  broadcast register address
slot_wr_data  out  DATA_W  broadcast write data
slot_rd_data  in  NUM_SLOTS*DATA_W  flattened; slot i at [i*DATA_W +: DATA_W]
slot_ready  in  NUM_SLOTS  slot completes the access this cycle
err_clr  in  1  clears err_count, err_sticky, overrun
err_count  out  ERR_CNT_W  saturating error count
err_sticky  out  1  any error since clear
err_addr  out  ADDR_W  address of most recent error
overrun  out  1  sticky: request received while busy

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0, including all strobes, mmio_rd_data, err_count and err_addr. Reset asserted mid-access drops the strobes immediately; no ack is issued for that access.
- Decode: reg = addr[REG_W-1:0]; slot = addr[REG_W+SLOT_W-1:REG_W]. Any nonzero address bit above REG_W+SLOT_W is a decode error.
- FSM: IDLE, ACCESS, RESP.
- IDLE: on mmio_cs=1, capture addr, wr_data and the read/write qualifiers into request registers. Set busy the next cycle.
  - Valid request: exactly one of read/write set, address in range, SLOT_PRESENT[slot]=1. Go to ACCESS.
  - Anything else (both or neither of read/write set, out-of-range address, absent slot): go to RESP flagged as error. No slot strobe is issued.
- ACCESS: drive slot_cs[slot], the matching rd or wr strobe, slot_mem_addr and slot_wr_data. All are held stable every cycle.
  - If slot_ready[slot]=1: capture slot data (reads) and go to RESP.
  - If TIMEOUT strobe cycles elapse without ready: go to RESP flagged as error.
- RESP (one cycle): strobes are 0; mmio_ack=1.
  - mmio_rd_data = captured slot data for a successful read, ERR_DATA for an errored read.
  - For writes, mmio_rd_data is unchanged.
  - mmio_busy=1 through RESP, 0 on return to IDLE.
- Latency: cs at cycle 0; strobes from cycle 1; with ready in cycle 1, ack in cycle 2. Error with no strobe: ack in cycle 2.
- mmio_rd_data holds its value until the next completed read.
- mmio_cs asserted while busy (ACCESS or RESP): the request is dropped and overrun is set. mmio_cs in the IDLE cycle after RESP is accepted.
- Error event (taken on entering RESP with error):
  - err_count increments, saturating at all-ones.
  - err_sticky=1.
  - err_addr = request address.
- err_clr in the same cycle as an error event: the clear applies first, so err_count=1 and err_sticky=1. err_clr never affects an access in flight.
- slot_ready of non-addressed slots, and slot_ready outside ACCESS, is ignored.

Test Plan:
- Read slot 0 (addr 21'h000003), slot_ready tied high, slot 0 data 32'h1234_5678 -> slot_cs[0] and slot_mem_rd[0] high in cycle 1 only, slot_mem_addr=3; ack in cycle 2 with mmio_rd_data=32'h1234_5678; err_count=0.
- Write addr 21'h0000A1 (slot 5, reg 1), data 32'hCAFE; slot 5 asserts ready after 3 wait cycles -> slot_mem_wr[5] held 4 cycles with data stable; ack 1 cycle after ready; busy deasserts the cycle after ack.
- Read slot 1 (absent) -> no strobe; ack at cycle 2 with 32'hFFFF_FFFF; err_count=1; err_addr=21'h000020.
- Read slot 4, ready never asserted -> strobe exactly 16 cycles, then ack with ERR_DATA; err_sticky=1; a second mmio_cs during the wait sets overrun and is not executed.
- Request with mmio_read=mmio_write=1, plus 256 forced errors -> no strobes; err_count saturates at 8'hFF; err_clr in the same cycle as the next error gives err_count=1.
- Assert reset low during an ACCESS wait -> all strobes drop in the same cycle; no ack; outputs 0; a read issued after reset release completes normally.

Source files
------------

// File: rtl/mmio_slot_fabric_if.sv
// rtl/mmio_slot_fabric_if.sv - host-side MMIO bus between the FPro bridge and the slot fabric
interface mmio_slot_fabric_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              mmio_cs;
    logic              mmio_read;
    logic              mmio_write;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;
    logic              mmio_ack;
    logic              mmio_busy;

    modport master (
        output mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data,
        input  mmio_rd_data, mmio_ack, mmio_busy
    );

    modport slave (
        input  mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data,
        output mmio_rd_data, mmio_ack, mmio_busy
    );
endinterface

// File: rtl/mmio_slot_fabric.sv
// rtl/mmio_slot_fabric.sv - MMIO slot decoder with wait states, timeout and error reporting
module mmio_slot_fabric #(
    parameter int                NUM_SLOTS    = 64,
    parameter int                REG_W        = 5,
    parameter int                ADDR_W       = 21,
    parameter int                DATA_W       = 32,
    parameter logic [63:0]       SLOT_PRESENT = 64'h0000_0000_0000_0031,
    parameter int                TIMEOUT      = 16,
    parameter logic [DATA_W-1:0] ERR_DATA     = 32'hFFFF_FFFF,
    parameter int                ERR_CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    mmio_slot_fabric_if.slave           bus,
    output logic [NUM_SLOTS-1:0]        slot_cs,
    output logic [NUM_SLOTS-1:0]        slot_mem_rd,
    output logic [NUM_SLOTS-1:0]        slot_mem_wr,
    output logic [REG_W-1:0]            slot_mem_addr,
    output logic [DATA_W-1:0]           slot_wr_data,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_rd_data,
    input  logic [NUM_SLOTS-1:0]        slot_ready,
    input  logic                        err_clr,
    output logic [ERR_CNT_W-1:0]        err_count,
    output logic                        err_sticky,
    output logic [ADDR_W-1:0]           err_addr,
    output logic                        overrun
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int DEC_W  = REG_W + SLOT_W;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [NUM_SLOTS-1:0] PRESENT = SLOT_PRESENT[NUM_SLOTS-1:0];

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_read;
    logic                req_write;
    logic                req_err;
    logic [TMR_W-1:0]    tmr;
    logic [DATA_W-1:0]   rd_data_q;
    logic [SLOT_W-1:0]   req_slot;
    logic [SLOT_W-1:0]   in_slot;
    logic                in_ok;
    logic                resp_err;
    logic                strobe_en;
    logic [NUM_SLOTS-1:0] slot_sel;

    assign in_slot  = bus.mmio_addr[DEC_W-1:REG_W];
    assign in_ok    = (bus.mmio_read ^ bus.mmio_write)
                    && ((bus.mmio_addr >> DEC_W) == '0)
                    && PRESENT[in_slot];
    assign req_slot = req_addr[DEC_W-1:REG_W];

    assign slot_mem_addr    = req_addr[REG_W-1:0];
    assign slot_wr_data     = req_wdata;
    assign bus.mmio_rd_data = rd_data_q;

    // State register; reset drops any access in flight without an ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state, strobes and host handshake outputs
    always_comb begin
        state_n      = state;
        resp_err     = 1'b0;
        strobe_en    = 1'b0;
        slot_sel     = '0;
        slot_cs      = '0;
        slot_mem_rd  = '0;
        slot_mem_wr  = '0;
        bus.mmio_ack  = 1'b0;
        bus.mmio_busy = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mmio_cs) state_n = ACCESS;
            end
            ACCESS: begin
                bus.mmio_busy = 1'b1;
                // A rejected request spends its ACCESS cycle with strobes masked
                strobe_en = !req_err;
                if (req_err) begin
                    state_n  = RESP;
                    resp_err = 1'b1;
                end else if (slot_ready[req_slot]) begin
                    state_n = RESP;
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    state_n  = RESP;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                bus.mmio_busy = 1'b1;
                bus.mmio_ack  = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (strobe_en) slot_sel = NUM_SLOTS'(1) << req_slot;
        slot_cs     = slot_sel;
        slot_mem_rd = req_read  ? slot_sel : '0;
        slot_mem_wr = req_write ? slot_sel : '0;
    end

    // Request capture, wait timer, read response and error bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_read   <= 1'b0;
            req_write  <= 1'b0;
            req_err    <= 1'b0;
            tmr        <= '0;
            rd_data_q  <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE && bus.mmio_cs) begin
                req_addr  <= bus.mmio_addr;
                req_wdata <= bus.mmio_wr_data;
                req_read  <= bus.mmio_read;
                req_write <= bus.mmio_write;
                req_err   <= !in_ok;
                tmr       <= '0;
            end
            if (state == ACCESS && state_n == ACCESS) tmr <= tmr + TMR_W'(1);

            // Pure writes leave the last read response in place
            if (state == ACCESS && state_n == RESP) begin
                if (!resp_err && req_read)
                    rd_data_q <= slot_rd_data[req_slot*DATA_W +: DATA_W];
                else if (resp_err && !(req_write && !req_read))
                    rd_data_q <= ERR_DATA;
            end

            if (err_clr) begin
                err_count  <= '0;
                err_sticky <= 1'b0;
                overrun    <= 1'b0;
            end
            if (state != IDLE && bus.mmio_cs) overrun <= 1'b1;

            // Clear takes effect before a coincident error is counted
            if (state == ACCESS && state_n == RESP && resp_err) begin
                if (err_clr)         err_count <= ERR_CNT_W'(1);
                else if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
                err_sticky <= 1'b1;
                err_addr   <= req_addr;
            end
        end
    end
endmodule

// File: tb/tb_mmio_slot_fabric.sv
// tb/tb_mmio_slot_fabric.sv - randomized self-checking bench for mmio_slot_fabric
module tb_mmio_slot_fabric;
    localparam int NS = 64;
    localparam int DW = 32;
    localparam int AW = 21;
    localparam int RW = 5;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_slot_fabric_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [NS-1:0]    slot_cs, slot_mem_rd, slot_mem_wr, slot_ready;
    logic [RW-1:0]    slot_mem_addr;
    logic [DW-1:0]    slot_wr_data;
    logic [NS*DW-1:0] slot_rd_data;
    logic             err_clr;
    logic [7:0]       err_count;
    logic             err_sticky;
    logic [AW-1:0]    err_addr;
    logic             overrun;

    mmio_slot_fabric dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .slot_cs(slot_cs), .slot_mem_rd(slot_mem_rd), .slot_mem_wr(slot_mem_wr),
        .slot_mem_addr(slot_mem_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data), .slot_ready(slot_ready),
        .err_clr(err_clr), .err_count(err_count), .err_sticky(err_sticky),
        .err_addr(err_addr), .overrun(overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] slot_mem [NS];
    int            m_cnt;
    bit            m_sticky, m_over;
    logic [AW-1:0] m_eaddr;
    logic [DW-1:0] m_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One host transaction; delay = wait cycles before the target raises ready
    task automatic run(input logic [AW-1:0] addr, input bit rd, input bit wr,
                       input logic [DW-1:0] wdata, input int delay,
                       input bit inject, input bit clr);
        logic [63:0] pres;
        logic [63:0] one_hot;
        bit   high, valid, err;
        int   slot, regn, strobes, ack_at, inj_k, seen, got_ack;
        bit   bad, busy_bad;
        pres    = 64'h31;
        high    = (addr >> 11) != 0;
        slot    = int'((addr >> 5) & 21'd63);
        regn    = int'(addr & 21'd31);
        one_hot = 64'd1 << slot;
        valid   = (rd != wr) && !high && pres[slot];
        strobes = !valid ? 0 : ((delay + 1 < TO) ? delay + 1 : TO);
        err     = !valid || (delay >= TO);
        ack_at  = 1 + ((strobes > 0) ? strobes : 1);
        inj_k   = ($urandom_range(0, 1) == 1) ? 1 : ack_at;
        seen    = 0;
        got_ack = -1;
        bad     = 1'b0;
        busy_bad = 1'b0;
        for (int k = 0; k <= 40 && got_ack < 0; k++) begin
            @(posedge clk); #1;
            bus.mmio_cs = (k == 0) || (inject && k == inj_k);
            if (k == 0) begin
                bus.mmio_addr = addr; bus.mmio_read = rd; bus.mmio_write = wr;
                bus.mmio_wr_data = wdata;
            end else begin
                bus.mmio_addr = 21'h0; bus.mmio_read = 1'b1; bus.mmio_write = 1'b0;
                bus.mmio_wr_data = $urandom;
            end
            err_clr = clr && (k == ack_at - 1);
            slot_ready = {$urandom, $urandom};
            slot_ready[slot] = (k >= 1) && (k - 1 >= delay);
            @(negedge clk);
            if (slot_cs != '0) begin
                seen++;
                if (slot_cs != one_hot || slot_mem_rd != (rd ? one_hot : 64'd0)
                    || slot_mem_wr != (wr ? one_hot : 64'd0)
                    || slot_mem_addr != RW'(regn) || slot_wr_data != wdata
                    || k != seen)
                    bad = 1'b1;
            end else if ((slot_mem_rd | slot_mem_wr) != '0) begin
                bad = 1'b1;
            end
            if ((k >= 1) != bus.mmio_busy) busy_bad = 1'b1;
            if (bus.mmio_ack) got_ack = k;
        end
        @(posedge clk); #1;
        bus.mmio_cs = 1'b0;
        err_clr = 1'b0;
        slot_ready = '0;
        @(negedge clk);

        if (clr) begin m_cnt = 0; m_sticky = 0; m_over = 0; end
        if (err) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_sticky = 1;
            m_eaddr = addr;
        end
        if (inject) m_over = 1;
        if (!err && rd) m_rd = slot_mem[slot];
        else if (err && !(wr && !rd)) m_rd = 32'hFFFF_FFFF;

        check("ack_cycle", 64'(got_ack), 64'(ack_at));
        check("strobe_cycles", 64'(seen), 64'(strobes));
        check("strobe_shape", 64'(bad), 64'd0);
        check("busy_during", 64'(busy_bad), 64'd0);
        check("idle_after", {62'd0, bus.mmio_busy, bus.mmio_ack}, 64'd0);
        check("rd_data", 64'(bus.mmio_rd_data), 64'(m_rd));
        check("err_count", 64'(err_count), 64'(m_cnt));
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        check("err_addr", 64'(err_addr), 64'(m_eaddr));
        check("overrun", 64'(overrun), 64'(m_over));
    endtask

    initial begin
        logic [AW-1:0] a;
        bit rd, wr, inj, clr;
        int mode;
        bus.mmio_cs = 0; bus.mmio_read = 0; bus.mmio_write = 0;
        bus.mmio_addr = '0; bus.mmio_wr_data = '0;
        slot_ready = '0; err_clr = 0;
        for (int i = 0; i < NS; i++) begin
            slot_mem[i] = $urandom;
        end
        slot_mem[0] = 32'h1234_5678;
        for (int i = 0; i < NS; i++) slot_rd_data[i*DW +: DW] = slot_mem[i];
        m_cnt = 0; m_sticky = 0; m_over = 0; m_eaddr = '0; m_rd = '0;

        #22;
        check("rst_strobes", 64'(slot_cs | slot_mem_rd | slot_mem_wr), 64'd0);
        check("rst_outputs", {bus.mmio_rd_data, 8'(err_count), 5'(slot_mem_addr),
                              bus.mmio_ack, bus.mmio_busy, err_sticky, overrun}, 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        @(negedge clk); reset = 1'b1;

        run(21'h000003, 1, 0, 32'h0, 0, 0, 0);
        run(21'h0000A1, 0, 1, 32'h0000_CAFE, 3, 0, 0);
        run(21'h000020, 1, 0, 32'h0, 0, 0, 0);
        run(21'h000080, 1, 0, 32'h0, 1000, 1, 0);

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: a = 21'(0 << 5);
                1: a = 21'(4 << 5);
                2: a = 21'(5 << 5);
                default: a = 21'($urandom_range(0, 63) << 5);
            endcase
            a = a | 21'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | (21'd1 << $urandom_range(11, 20));
            rd = (mode == 0) ? 1 : (mode == 1) ? 0 : mode[0];
            wr = (mode == 0) ? 1 : (mode == 1) ? 0 : !mode[0];
            clr = ($urandom_range(0, 5) == 0);
            inj = !clr && ($urandom_range(0, 4) == 0);
            run(a, rd, wr, $urandom, $urandom_range(0, 20), inj, clr);
        end

        for (int i = 0; i < 256; i++) run(21'($urandom_range(0, 2047)), 1, 1, 32'h0, 0, 0, 0);
        run(21'h000044, 1, 1, 32'h0, 0, 0, 1);

        @(posedge clk); #1;
        bus.mmio_cs = 1; bus.mmio_addr = 21'h000080; bus.mmio_read = 1; bus.mmio_write = 0;
        slot_ready = '0;
        @(posedge clk); #1; bus.mmio_cs = 0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_strobe", 64'(slot_mem_rd), 64'd1 << 4);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_strobes", 64'(slot_cs | slot_mem_rd | slot_mem_wr), 64'd0);
        check("mid_rst_outputs", {bus.mmio_rd_data, 8'(err_count), 5'(slot_mem_addr),
                                  bus.mmio_ack, bus.mmio_busy, err_sticky, overrun}, 64'd0);
        check("mid_rst_err_addr", 64'(err_addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_no_ack", 64'(bus.mmio_ack), 64'd0);
        reset = 1'b1;
        m_cnt = 0; m_sticky = 0; m_over = 0; m_eaddr = '0; m_rd = '0;
        run(21'h000083, 1, 0, 32'h0, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
